// File: rtl/accel_servo_map.sv
// Maps three signed accelerometer axes to servo duty counts through a shared
// filter/clamp/map datapath. Optional slew limiting is enabled by ACCEL_MAP_SLEW_EN.
module accel_servo_map #(
    parameter int RANGE      = 2000,
    parameter int GAIN       = 25,
    parameter int MIN_DC     = 25_000,
    parameter int MAX_DC     = 125_000,
    parameter int FILT_SHIFT = 2,
    parameter int SLEW_STEP  = 10_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_update,
    input  logic [15:0] data_x,
    input  logic [15:0] data_y,
    input  logic [15:0] data_z,
    output logic [31:0] dc_x,
    output logic [31:0] dc_y,
    output logic [31:0] dc_z,
    output logic        dc_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned SW  = 16;
    localparam int unsigned FW  = 18;
    localparam int unsigned PW  = 48;
    localparam int unsigned DW  = 32;
    localparam int unsigned NAX = 3;

    localparam logic signed [PW-1:0] CENTER  = PW'((MIN_DC + MAX_DC) / 2);
    localparam logic signed [PW-1:0] RANGE_P = PW'(RANGE);
    localparam logic signed [PW-1:0] RANGE_N = -PW'(RANGE);
    localparam logic signed [PW-1:0] GAIN_P  = PW'(GAIN);
    localparam logic signed [PW-1:0] MIN_P   = PW'(MIN_DC);
    localparam logic signed [PW-1:0] MAX_P   = PW'(MAX_DC);

    // Reject configurations whose limits are inverted or whose slew step is negative
    if (MIN_DC > MAX_DC || SLEW_STEP < 0) begin : g_bad_cfg
        $error("accel_servo_map: invalid MIN_DC/MAX_DC/SLEW_STEP configuration");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILT,
        S_CLAMP,
        S_MAP,
        S_COMMIT
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             axis_q, axis_d;
    logic                   upd_q;
    logic signed [SW-1:0]   samp_q [NAX];
    logic signed [SW-1:0]   samp_d [NAX];
    logic signed [FW-1:0]   filt_q [NAX];
    logic signed [FW-1:0]   filt_d [NAX];
    logic                   first_q, first_d;
    logic signed [PW-1:0]   work_q, work_d;
    logic [DW-1:0]          dc_q [NAX];
    logic [DW-1:0]          dc_d [NAX];
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;

    logic                   edge_c;
    logic signed [FW-1:0]   s_ext_c, f_cur_c, f_diff_c, f_new_c;
    logic signed [PW-1:0]   m_raw_c;
`ifdef ACCEL_MAP_SLEW_EN
    localparam logic signed [PW-1:0] SLEW_P = PW'(SLEW_STEP);
    logic signed [PW-1:0]   cur_dc_c, delta_c, step_c;
`endif

    assign edge_c = data_update & ~upd_q;

    // Next-state and datapath for the one shared axis pipeline
    always_comb begin
        state_d = state_q;
        axis_d  = axis_q;
        samp_d  = samp_q;
        filt_d  = filt_q;
        first_d = first_q;
        work_d  = work_q;
        dc_d    = dc_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;

        s_ext_c  = FW'(samp_q[axis_q]);
        f_cur_c  = filt_q[axis_q];
        f_diff_c = s_ext_c - f_cur_c;
        f_new_c  = first_q ? s_ext_c : f_cur_c + (f_diff_c >>> FILT_SHIFT);
        m_raw_c  = work_q * GAIN_P + CENTER;
`ifdef ACCEL_MAP_SLEW_EN
        cur_dc_c = PW'(dc_q[axis_q]);
        delta_c  = work_q - cur_dc_c;
        step_c   = (delta_c > SLEW_P) ? SLEW_P :
                   (delta_c < -SLEW_P) ? -SLEW_P : delta_c;
`endif

        if (edge_c && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (edge_c) begin
                    samp_d[0] = data_x;
                    samp_d[1] = data_y;
                    samp_d[2] = data_z;
                    axis_d    = 2'd0;
                    state_d   = S_FILT;
                end
            end
            S_FILT: begin
                filt_d[axis_q] = f_new_c;
                work_d         = PW'(f_new_c);
                state_d        = S_CLAMP;
            end
            S_CLAMP: begin
                if (work_q > RANGE_P) begin
                    work_d = RANGE_P;
                end else if (work_q < RANGE_N) begin
                    work_d = RANGE_N;
                end
                state_d = S_MAP;
            end
            S_MAP: begin
                // Re-clamp so an oversized GAIN can never drive past the servo limits
                if (m_raw_c > MAX_P) begin
                    work_d = MAX_P;
                end else if (m_raw_c < MIN_P) begin
                    work_d = MIN_P;
                end else begin
                    work_d = m_raw_c;
                end
                state_d = S_MAP == S_MAP ? S_COMMIT : S_COMMIT;
            end
            S_COMMIT: begin
`ifdef ACCEL_MAP_SLEW_EN
                dc_d[axis_q] = DW'(cur_dc_c + step_c);
`else
                dc_d[axis_q] = DW'(work_q);
`endif
                if (axis_q == 2'd2) begin
                    valid_d = 1'b1;
                    first_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    axis_d  = axis_q + 2'd1;
                    state_d = S_FILT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            axis_q  <= 2'd0;
            upd_q   <= 1'b0;
            first_q <= 1'b1;
            work_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < NAX; i++) begin
                samp_q[i] <= '0;
                filt_q[i] <= '0;
                dc_q[i]   <= DW'(CENTER);
            end
        end else begin
            state_q <= state_d;
            axis_q  <= axis_d;
            upd_q   <= data_update;
            first_q <= first_d;
            work_q  <= work_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            for (int i = 0; i < NAX; i++) begin
                samp_q[i] <= samp_d[i];
                filt_q[i] <= filt_d[i];
                dc_q[i]   <= dc_d[i];
            end
        end
    end

    assign dc_x     = dc_q[0];
    assign dc_y     = dc_q[1];
    assign dc_z     = dc_q[2];
    assign dc_valid = valid_q;
    assign busy     = busy_q;
    assign overrun  = ovr_q;

endmodule
